// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: shadow stage records and
// EX operand forwarding selects.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_wr;
      logic                  is_load;
   } stage_rec_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   localparam stage_rec_t REC_NONE = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one source register index against one in-flight destination record.
module hazard_match
   import hazard_pkg::*;
(
   input  stage_rec_t            rec,
   input  logic [REG_ADDR_W-1:0] rs,
   output logic                  hit
);

   // x0 is hardwired zero, so a write to it never produces a usable value
   assign hit = rec.valid & rec.reg_wr & (rec.rd != '0) & (rec.rd == rs);

   logic unused_load;
   assign unused_load = rec.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: tracks EX/MEM/WB destination records and
// derives buffer enables, flushes, bubbles and registered forwarding selects.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_wr,
   input  logic                  id_is_load,
   input  logic                  ex_branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  if_id_flush,
   output logic                  id_ex_en,
   output logic                  id_ex_bubble,
   output logic                  back_en,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic [CNT_W-1:0]      stall_cycles
);

   stage_rec_t ex_rec, mem_rec, wb_rec, id_rec;
   fwd_sel_t   fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic       load_use_c, count_c;

   assign id_rec = '{valid: id_valid, rd: id_rd, reg_wr: id_reg_wr, is_load: id_is_load};

   hazard_match u_ex_a  (.rec(ex_rec),  .rs(id_rs1), .hit(ex_hit_a));
   hazard_match u_ex_b  (.rec(ex_rec),  .rs(id_rs2), .hit(ex_hit_b));
   hazard_match u_mem_a (.rec(mem_rec), .rs(id_rs1), .hit(mem_hit_a));
   hazard_match u_mem_b (.rec(mem_rec), .rs(id_rs2), .hit(mem_hit_b));

   assign load_use_c = id_valid & ex_rec.is_load &
                       ((id_rs1_used & ex_hit_a) | (id_rs2_used & ex_hit_b));

   // Freeze beats branch flush beats load-use stall
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      back_en      = 1'b1;
      count_c      = 1'b0;
      if (mem_busy) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         id_ex_en = 1'b0;
         back_en  = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use_c) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_bubble = 1'b1;
         count_c      = 1'b1;
      end
   end

   // Newest producer wins: EX/MEM result is checked before MEM/WB
   always_comb begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (id_rs1_used & ex_hit_a)       fwd_a_d = FWD_EXMEM;
      else if (id_rs1_used & mem_hit_a) fwd_a_d = FWD_MEMWB;
      if (id_rs2_used & ex_hit_b)       fwd_b_d = FWD_EXMEM;
      else if (id_rs2_used & mem_hit_b) fwd_b_d = FWD_MEMWB;
      if (id_ex_bubble) begin
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rec       <= REC_NONE;
         mem_rec      <= REC_NONE;
         wb_rec       <= REC_NONE;
         fwd_a_q      <= FWD_RF;
         fwd_b_q      <= FWD_RF;
         stall_cycles <= '0;
      end else if (!mem_busy) begin
         wb_rec  <= mem_rec;
         mem_rec <= ex_rec;
         ex_rec  <= id_ex_bubble ? REC_NONE : id_rec;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         if (count_c && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
      end
   end

   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;

   // WB writes land in the register file write-first, so the WB record has no reader here
   logic unused_wb;
   assign unused_wb = ^wb_rec;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a stage-list reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        ex_branch_taken, mem_busy;
   logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] stall_cycles;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .back_en(back_en),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: list of in-flight producers, index 0 = EX, 1 = MEM, 2 = WB
   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } mrec_t;

   mrec_t   pipe [3];
   int      m_fa, m_fb;
   longint  m_cnt;

   function automatic bit mhit(int s, int rs);
      return pipe[s].v && pipe[s].wr && (pipe[s].rd != 0) && (pipe[s].rd == rs);
   endfunction

   // Forward from the youngest stage holding the value; encoding is stage index + 1
   function automatic int newest(bit used, int rs);
      if (!used) return 0;
      for (int s = 0; s < 2; s++) if (mhit(s, rs)) return s + 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         pipe[s].v = 0; pipe[s].rd = 0; pipe[s].wr = 0; pipe[s].ld = 0;
      end
      m_fa = 0; m_fb = 0; m_cnt = 0;
   endtask

   task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit br, input bit busy);
      bit lu, bub;
      logic [5:0] exp_ctrl;
      int nfa, nfb;
      @(negedge clk);
      id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2);
      id_rs1_used = u1; id_rs2_used = u2;
      id_rd = 5'(rd); id_reg_wr = wr; id_is_load = ld;
      ex_branch_taken = br; mem_busy = busy;
      #1;
      lu = v && pipe[0].ld && ((u1 && mhit(0, r1)) || (u2 && mhit(0, r2)));
      // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en}
      if (busy)    exp_ctrl = 6'b000000;
      else if (br) exp_ctrl = 6'b111111;
      else if (lu) exp_ctrl = 6'b000111;
      else         exp_ctrl = 6'b110101;
      check("ctrl", 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, back_en}),
            32'(exp_ctrl));
      check("fwd_a", 32'(fwd_a_sel), 32'(m_fa));
      check("fwd_b", 32'(fwd_b_sel), 32'(m_fb));
      check("stall_cnt", stall_cycles, 32'(m_cnt));
      if (!busy) begin
         bub = br || lu;
         nfa = bub ? 0 : newest(u1, r1);
         nfb = bub ? 0 : newest(u2, r2);
         if (!br && lu && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0].v  = bub ? 1'b0 : v;
         pipe[0].rd = bub ? 0 : rd;
         pipe[0].wr = bub ? 1'b0 : wr;
         pipe[0].ld = bub ? 1'b0 : ld;
         m_fa = nfa;
         m_fb = nfb;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   longint base;

   initial begin
      rst = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_reg_wr = 0; id_is_load = 0; ex_branch_taken = 0; mem_busy = 0;
      model_reset();
      #1;
      check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
      check("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
      check("rst_stall", stall_cycles, 32'd0);
      check("rst_pc_en", 32'(pc_en), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // add x5 ; add x6,x5,x1 -> EX/MEM forward, no stall
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
      check("fwd_ex_no_stall", 32'(pc_en), 32'd1);
      idle();
      check("fwd_ex_sel", 32'(fwd_a_sel), 32'd1);
      check("fwd_ex_cnt", stall_cycles, 32'd0);

      // lw x7 ; add x8,x7,x7 -> one bubble then MEM/WB forward
      base = m_cnt;
      step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      check("lu_pc_en", 32'(pc_en), 32'd0);
      check("lu_if_id_en", 32'(if_id_en), 32'd0);
      check("lu_bubble", 32'(id_ex_bubble), 32'd1);
      step(1, 7, 7, 1, 1, 8, 1, 0, 0, 0);
      check("lu_release", 32'(pc_en), 32'd1);
      idle();
      check("lu_fwd_a", 32'(fwd_a_sel), 32'd2);
      check("lu_fwd_b", 32'(fwd_b_sel), 32'd2);
      check("lu_cnt", stall_cycles, 32'(base + 1));

      // lw x0 ; consumer of x0 -> nothing
      base = m_cnt;
      step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
      check("x0_no_stall", 32'(pc_en), 32'd1);
      idle();
      check("x0_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
      check("x0_cnt", stall_cycles, 32'(base));

      // taken branch masks a load-use
      base = m_cnt;
      step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
      step(1, 9, 0, 1, 0, 3, 1, 0, 1, 0);
      check("br_flush", 32'(if_id_flush), 32'd1);
      check("br_pc_en", 32'(pc_en), 32'd1);
      step(1, 9, 0, 1, 0, 3, 1, 0, 0, 0);
      check("br_ex_invalid", 32'(pc_en), 32'd1);
      check("br_cnt", stall_cycles, 32'(base));

      // mem_busy freezes a pending load-use for 3 cycles
      base = m_cnt;
      step(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 10, 10, 1, 1, 11, 1, 0, 0, 1);
         check("busy_en", 32'({pc_en, if_id_en, id_ex_en, back_en}), 32'd0);
      end
      step(1, 10, 10, 1, 1, 11, 1, 0, 0, 0);
      check("busy_then_stall", 32'(id_ex_bubble), 32'd1);
      step(1, 10, 10, 1, 1, 11, 1, 0, 0, 0);
      idle();
      check("busy_fwd", 32'(fwd_a_sel), 32'd2);
      check("busy_cnt", stall_cycles, 32'(base + 1));

      // asynchronous reset in the middle of a load-use stall
      step(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
      @(negedge clk);
      id_valid = 1; id_rs1 = 5'd11; id_rs1_used = 1; id_rs2_used = 0;
      id_rd = 5'd12; id_reg_wr = 1; id_is_load = 0; ex_branch_taken = 0; mem_busy = 0;
      #1;
      check("rst_pre_stall", 32'(pc_en), 32'd0);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_mid_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
      check("rst_mid_cnt", stall_cycles, 32'd0);
      check("rst_mid_pc_en", 32'(pc_en), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      step(1, 11, 0, 1, 0, 12, 1, 0, 0, 0);

      // randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 6) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of destination-register records for the EX, MEM and WB stages.
- From these records it drives the enables, flushes and bubbles for the pipeline buffers (PC, IF/ID, and the ID/EX operand buffers including rs1/rs2), plus the registered forwarding selects for the EX operand muxes.
- Resolves load-use hazards, taken-branch flushes and data-memory wait freezes.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; rst, asynchronous, active-high; clock clk.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_ADDR_W  source 1 index in ID.
- id_rs2  input  REG_ADDR_W  source 2 index in ID.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_used  input  1  instruction reads rs2.
- id_rd  input  REG_ADDR_W  destination index in ID.
- id_reg_wr  input  1  instruction writes rd.
- id_is_load  input  1  instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- mem_busy  input  1  data memory not ready; whole pipeline must freeze.
- pc_en  output  1  PC update enable.
- if_id_en  output  1  IF/ID buffer load enable.
- if_id_flush  output  1  IF/ID buffer clear to NOP.
- id_ex_en  output  1  ID/EX buffers (rs1/rs2/imm/ctrl) load enable.
- id_ex_bubble  output  1  ID/EX loads NOP instead of ID contents.
- back_en  output  1  EX/MEM and MEM/WB buffer enable.
- fwd_a_sel  output  2  EX operand A source.
- fwd_b_sel  output  2  EX operand B source.
- stall_cycles  output  CNT_W  count of load-use stall cycles.

Behaviour:
- Record = {valid, rd, reg_wr, is_load}. Registers ex_rec, mem_rec, wb_rec. Reset: all records invalid; fwd_a_sel = fwd_b_sel = 2'b00; stall_cycles = 0.
- fwd encoding: 00 register file (write-first, so the WB-stage write is visible to ID reads), 01 EX/MEM result, 10 MEM/WB result.
- hit(rec, rs) = rec.valid & rec.reg_wr & rec.rd != 0 & rec.rd == rs.
- load_use (combinational) = id_valid & ex_rec.is_load & ((id_rs1_used & hit(ex_rec, id_rs1)) | (id_rs2_used & hit(ex_rec, id_rs2))).
- Priority, evaluated every cycle, highest first:
  1. mem_busy: all enables 0, flush 0, bubble 0. Every record, fwd sel and counter holds.
  2. ex_branch_taken: pc_en = 1, if_id_flush = 1, id_ex_en = 1, id_ex_bubble = 1, back_en = 1. A load_use in the same cycle is ignored and not counted.
  3. load_use: pc_en = 0, if_id_en = 0, id_ex_en = 1, id_ex_bubble = 1, back_en = 1. stall_cycles increments, saturating at all-ones.
  4. Otherwise: all enables 1, flush 0, bubble 0.
- Stall and enable outputs are combinational. Records and fwd sels are registered.
- Record advance whenever not mem_busy:
  - wb_rec <= mem_rec; mem_rec <= ex_rec.
  - ex_rec <= invalid if bubbling, else the ID record (valid = id_valid).
- fwd sel update on the same condition, per operand:
  - 01 if used & hit(ex_rec, rs);
  - else 10 if used & hit(mem_rec, rs);
  - else 00.
  - Forced to 00 when bubbling.
  - The newest producer wins.
- Load-use therefore costs exactly 1 bubble. On the following cycle the load sits in MEM and the consumer gets fwd = 10.
- rd = x0 never forwards and never stalls.
- Reset mid-stall or mid-freeze returns every record to invalid immediately (asynchronous). Outputs revert to the "otherwise" values.

Decomposition:
- Package hazard_pkg: stage_rec_t struct, fwd_sel_t enum (FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10), REG_ADDR_W constant.
- One sub-module, hazard_match: combinational rs-vs-record comparator returning hit. Instantiated for each record/operand pair.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back → the second instruction enters EX with fwd_a_sel = 01, no stall, stall_cycles = 0.
- lw x7 then add x8,x7,x7 → 1 cycle with pc_en = 0, if_id_en = 0, id_ex_bubble = 1; next cycle fwd_a_sel = fwd_b_sel = 10; stall_cycles = 1.
- lw x0 then a consumer of x0 → no stall, fwd sels 00.
- ex_branch_taken together with a load_use condition → if_id_flush = 1, pc_en = 1, stall_cycles unchanged, ex_rec invalid next cycle.
- mem_busy held 3 cycles during a load_use → all enables 0 for 3 cycles, records and fwd sels unchanged; the stall completes after mem_busy drops.
- Assert rst during a load_use stall → fwd sels 00, records invalid, pc_en = 1 on the next cycle, stall_cycles = 0.
